// File: rtl/coin_pkg.sv
// Shared constants for the coin sprite sheet, also imported by the coin renderer.
package coin_pkg;
    localparam int COIN_W          = 16;
    localparam int COIN_FRAME_H    = 16;
    localparam int NUM_FRAMES      = 4;
    localparam int COIN_ADDR_W     = 10;
    localparam int COIN_FRAME_BITS = 2;
    localparam int COIN_SHEET_SIZE = COIN_W * COIN_FRAME_H * NUM_FRAMES;
    localparam int COIN_W_SHIFT    = $clog2(COIN_W);
    localparam int COIN_H_SHIFT    = $clog2(COIN_FRAME_H);
    localparam int COIN_FRAME_SHIFT = COIN_W_SHIFT + COIN_H_SHIFT;
endpackage

// File: rtl/coin_anim_counter.sv
// Animation step counter: one frame step every TICKS_PER_STEP enabled video frames.
module coin_anim_counter
    import coin_pkg::*;
#(
    parameter int TICKS_PER_STEP = 8
) (
    input  logic                       pixel_clk_in,
    input  logic                       rst_in,
    input  logic                       new_frame_in,
    input  logic                       anim_en_in,
    output logic [COIN_FRAME_BITS-1:0] frame_out
);
    localparam int TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);

    logic [TICK_W-1:0] tick;

    // Frame index wraps on its own because NUM_FRAMES is a power of two.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            tick      <= '0;
            frame_out <= '0;
        end else if (new_frame_in && anim_en_in) begin
            if (tick == TICK_LAST) begin
                tick      <= '0;
                frame_out <= frame_out + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end
endmodule

// File: rtl/coin_sprite_addr_gen.sv
// Coin sheet address generator with per-frame position latch; COIN_SCALE2X_EN
// doubles the on-screen footprint (each texel covers 2x2 pixels).
module coin_sprite_addr_gen
    import coin_pkg::*;
#(
    parameter int TICKS_PER_STEP = 8
) (
    input  logic                       pixel_clk_in,
    input  logic                       rst_in,
    input  logic [10:0]                hcount_in,
    input  logic [9:0]                 vcount_in,
    input  logic                       new_frame_in,
    input  logic [10:0]                coin_x_in,
    input  logic [9:0]                 coin_y_in,
    input  logic                       coin_active_in,
    input  logic                       anim_en_in,
    output logic [COIN_ADDR_W-1:0]     image_addr,
    output logic                       in_sprite,
    output logic [COIN_FRAME_BITS-1:0] anim_frame_out
);
`ifdef COIN_SCALE2X_EN
    localparam int SCALE_SHIFT = 1;
`else
    localparam int SCALE_SHIFT = 0;
`endif
    localparam int SPAN_W      = COIN_W << SCALE_SHIFT;
    localparam int SPAN_H      = COIN_FRAME_H << SCALE_SHIFT;
    localparam int ADDR_CALC_W = 12;

    logic [10:0]                shadow_x;
    logic [9:0]                 shadow_y;
    logic                       shadow_active;
    logic [COIN_FRAME_BITS-1:0] frame;

    coin_anim_counter #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_anim (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .new_frame_in (new_frame_in),
        .anim_en_in   (anim_en_in),
        .frame_out    (frame)
    );

    assign anim_frame_out = frame;

    // Coin position is sampled once per video frame so a sprite never tears mid-scan.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            shadow_x      <= '0;
            shadow_y      <= '0;
            shadow_active <= 1'b0;
        end else if (new_frame_in) begin
            shadow_x      <= coin_x_in;
            shadow_y      <= coin_y_in;
            shadow_active <= coin_active_in;
        end
    end

    logic                   hit_h, hit_v, hit;
    logic [10:0]            h_off;
    logic [9:0]             v_off;
    logic [COIN_ADDR_W-1:0] addr_next;

    // One extra bit on each axis keeps shadow + span from wrapping to column/row 0.
    always_comb begin
        hit_h = ({1'b0, hcount_in} >= {1'b0, shadow_x}) &&
                ({1'b0, hcount_in} <  ({1'b0, shadow_x} + 12'(SPAN_W)));
        hit_v = ({1'b0, vcount_in} >= {1'b0, shadow_y}) &&
                ({1'b0, vcount_in} <  ({1'b0, shadow_y} + 11'(SPAN_H)));
        hit   = hit_h && hit_v && shadow_active;
        h_off = hcount_in - shadow_x;
        v_off = vcount_in - shadow_y;
        addr_next = COIN_ADDR_W'((ADDR_CALC_W'(frame) << COIN_FRAME_SHIFT) +
                                 (ADDR_CALC_W'(v_off >> SCALE_SHIFT) << COIN_W_SHIFT) +
                                 ADDR_CALC_W'(h_off >> SCALE_SHIFT));
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            image_addr <= '0;
            in_sprite  <= 1'b0;
        end else begin
            in_sprite <= hit;
            if (hit) begin
                image_addr <= addr_next;
            end
        end
    end
endmodule

// File: tb/tb_coin_sprite_addr_gen.sv
// Bench for coin_sprite_addr_gen; builds with or without COIN_SCALE2X_EN.
module tb_coin_sprite_addr_gen;
    localparam int TICKS = 8;
`ifdef COIN_SCALE2X_EN
    localparam int SC = 2;
`else
    localparam int SC = 1;
`endif

    logic        pixel_clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        new_frame_in = 1'b0;
    logic [10:0] coin_x_in = '0;
    logic [9:0]  coin_y_in = '0;
    logic        coin_active_in = 1'b0;
    logic        anim_en_in = 1'b0;
    logic [9:0]  image_addr;
    logic        in_sprite;
    logic [1:0]  anim_frame_out;

    coin_sprite_addr_gen #(.TICKS_PER_STEP(TICKS)) dut (
        .pixel_clk_in   (pixel_clk_in),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .new_frame_in   (new_frame_in),
        .coin_x_in      (coin_x_in),
        .coin_y_in      (coin_y_in),
        .coin_active_in (coin_active_in),
        .anim_en_in     (anim_en_in),
        .image_addr     (image_addr),
        .in_sprite      (in_sprite),
        .anim_frame_out (anim_frame_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: shadow position plus a count of enabled frame pulses.
    int         m_sx = 0, m_sy = 0, m_pulses = 0;
    bit         m_act = 1'b0;
    logic [9:0] exp_addr = '0;
    logic       exp_in = 1'b0;
    logic [1:0] exp_frame = '0;

    task automatic cycle(input bit rst, input bit nf, input int h, input int v);
        int f;
        bit hit;
        rst_in       = rst;
        new_frame_in = nf;
        hcount_in    = 11'(h);
        vcount_in    = 10'(v);
        @(posedge pixel_clk_in);
        if (rst) begin
            m_sx = 0; m_sy = 0; m_act = 1'b0; m_pulses = 0;
            exp_addr = '0; exp_in = 1'b0;
        end else begin
            f   = (m_pulses / TICKS) % 4;
            hit = m_act && h >= m_sx && h < m_sx + 16*SC && v >= m_sy && v < m_sy + 16*SC;
            exp_in = hit;
            if (hit) exp_addr = 10'((f*256 + ((v - m_sy)/SC)*16 + (h - m_sx)/SC) % 1024);
            if (nf) begin
                m_sx = int'(coin_x_in); m_sy = int'(coin_y_in); m_act = coin_active_in;
                if (anim_en_in) m_pulses++;
            end
        end
        exp_frame = 2'((m_pulses / TICKS) % 4);
        @(negedge pixel_clk_in);
        rst_in = 1'b0;
        new_frame_in = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        n_checks++;
        if (in_sprite !== 1'b0 || image_addr !== 10'd0 || anim_frame_out !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_values: in_sprite=%b addr=%0d frame=%0d, want 0/0/0",
                     in_sprite, image_addr, anim_frame_out);
        end
        coin_x_in = 11'd100; coin_y_in = 10'd50; coin_active_in = 1'b1;
        for (int h = 0; h < 1024; h++) begin
            cycle(0, 0, h, 50);
            n_checks++;
            if (in_sprite !== 1'b0 || image_addr !== 10'd0) begin
                n_fail++;
                $display("FAIL no_latch_line h=%0d: in_sprite=%b addr=%0d, want 0/0", h, in_sprite, image_addr);
            end
        end
    endtask

    task automatic test_basic_hit();
        coin_x_in = 11'd100; coin_y_in = 10'd50; coin_active_in = 1'b1; anim_en_in = 1'b0;
        cycle(0, 1, 0, 0);
        for (int h = 90; h < 130; h++) begin
            cycle(0, 0, h, 50);
            n_checks++;
            if (in_sprite !== exp_in || image_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL row50 h=%0d: in_sprite=%b addr=%0d, want %b/%0d", h, in_sprite, image_addr, exp_in, exp_addr);
            end
            if (h == 100) begin
                n_checks++;
                if (in_sprite !== 1'b1 || image_addr !== 10'd0) begin
                    n_fail++;
                    $display("FAIL first_texel: in_sprite=%b addr=%0d, want 1/0", in_sprite, image_addr);
                end
            end
        end
        for (int h = 100; h < 116; h++) begin
            cycle(0, 0, h, 65);
            n_checks++;
            if (in_sprite !== exp_in || image_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL row65 h=%0d: in_sprite=%b addr=%0d, want %b/%0d", h, in_sprite, image_addr, exp_in, exp_addr);
            end
        end
`ifndef COIN_SCALE2X_EN
        n_checks++;
        if (image_addr !== 10'd255) begin
            n_fail++;
            $display("FAIL last_texel: addr=%0d, want 255", image_addr);
        end
`endif
    endtask

    task automatic test_scale();
`ifdef COIN_SCALE2X_EN
        int hs[3] = '{100, 101, 102};
        int vs[3] = '{50, 51, 50};
        logic [9:0] want[3] = '{10'd0, 10'd0, 10'd1};
        coin_x_in = 11'd100; coin_y_in = 10'd50; coin_active_in = 1'b1; anim_en_in = 1'b0;
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, hs[i], vs[i]);
            n_checks++;
            if (in_sprite !== 1'b1 || image_addr !== want[i]) begin
                n_fail++;
                $display("FAIL scale2x (%0d,%0d): in_sprite=%b addr=%0d, want 1/%0d", hs[i], vs[i], in_sprite, image_addr, want[i]);
            end
        end
`endif
    endtask

    task automatic test_anim();
        coin_x_in = 11'd100; coin_y_in = 10'd50; coin_active_in = 1'b1; anim_en_in = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cycle(0, 1, 0, 0);
            n_checks++;
            if (anim_frame_out !== exp_frame || anim_frame_out !== 2'(((i + 1) / 8) % 4)) begin
                n_fail++;
                $display("FAIL anim pulse %0d: frame=%0d, want %0d", i + 1, anim_frame_out, ((i + 1) / 8) % 4);
            end
            if (i == 15) begin
                cycle(0, 0, 100, 50);
                n_checks++;
                if (in_sprite !== 1'b1 || image_addr !== 10'd512) begin
                    n_fail++;
                    $display("FAIL frame2_addr: in_sprite=%b addr=%0d, want 1/512", in_sprite, image_addr);
                end
            end
        end
        anim_en_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 0);
            n_checks++;
            if (anim_frame_out !== exp_frame) begin
                n_fail++;
                $display("FAIL anim_hold %0d: frame=%0d, want %0d", i, anim_frame_out, exp_frame);
            end
        end
    endtask

    task automatic test_mid_frame();
        coin_x_in = 11'd100; coin_y_in = 10'd50; coin_active_in = 1'b1; anim_en_in = 1'b0;
        cycle(0, 1, 0, 0);
        coin_x_in = 11'd200;
        for (int pass = 0; pass < 2; pass++) begin
            for (int h = 95; h < 222; h++) begin
                cycle(0, 0, h, 52);
                n_checks++;
                if (in_sprite !== exp_in || image_addr !== exp_addr ||
                    in_sprite !== ((pass == 0) ? (h >= 100 && h < 100 + 16*SC) : (h >= 200 && h < 200 + 16*SC))) begin
                    n_fail++;
                    $display("FAIL mid_frame pass%0d h=%0d: in_sprite=%b addr=%0d, want %b/%0d", pass, h, in_sprite, image_addr, exp_in, exp_addr);
                end
            end
            cycle(0, 1, 0, 0);
        end
    endtask

    task automatic test_offscreen();
        coin_x_in = 11'd1020; coin_y_in = 10'd50; anim_en_in = 1'b0;
        for (int act = 0; act < 2; act++) begin
            coin_active_in = act[0];
            cycle(0, 1, 0, 0);
            for (int k = 0; k < 26; k++) begin
                int h = (k < 14) ? 1010 + k : k - 14;
                int v = (k < 14) ? 50 : 51;
                cycle(0, 0, h, v);
                n_checks++;
                if (in_sprite !== exp_in || image_addr !== exp_addr ||
                    in_sprite !== (act == 1 && h >= 1020)) begin
                    n_fail++;
                    $display("FAIL offscreen act=%0d (%0d,%0d): in_sprite=%b addr=%0d, want %b/%0d", act, h, v, in_sprite, image_addr, exp_in, exp_addr);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        coin_x_in = 11'd100; coin_y_in = 10'd50; coin_active_in = 1'b1; anim_en_in = 1'b1;
        for (int i = 0; i < 40 && exp_frame != 2'd3; i++) cycle(0, 1, 0, 0);
        anim_en_in = 1'b0;
        cycle(0, 0, 105, 55);
        n_checks++;
        if (in_sprite !== 1'b1 || anim_frame_out !== 2'd3) begin
            n_fail++;
            $display("FAIL pre_reset: in_sprite=%b frame=%0d, want 1/3", in_sprite, anim_frame_out);
        end
        cycle(1, 0, 106, 55);
        n_checks++;
        if (in_sprite !== 1'b0 || image_addr !== 10'd0 || anim_frame_out !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset: in_sprite=%b addr=%0d frame=%0d, want 0/0/0", in_sprite, image_addr, anim_frame_out);
        end
        for (int h = 98; h < 120; h++) begin
            cycle(0, 0, h, 55);
            n_checks++;
            if (in_sprite !== 1'b0 || image_addr !== 10'd0) begin
                n_fail++;
                $display("FAIL post_reset h=%0d: in_sprite=%b addr=%0d, want 0/0", h, in_sprite, image_addr);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            bit rst = ($urandom_range(0, 499) == 0);
            bit nf  = ($urandom_range(0, 39) == 0);
            int h, v;
            if ($urandom_range(0, 9) == 0) begin
                coin_x_in = 11'($urandom_range(0, 1030));
                coin_y_in = 10'($urandom_range(0, 700));
                coin_active_in = ($urandom_range(0, 3) != 0);
            end
            anim_en_in = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 0) begin
                h = m_sx + $urandom_range(0, 16*SC + 8) - 4;
                v = m_sy + $urandom_range(0, 16*SC + 8) - 4;
                if (h < 0) h = 0;
                if (h > 1023) h = 1023;
                if (v < 0) v = 0;
                if (v > 767) v = 767;
            end else begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 767);
            end
            cycle(rst, nf, h, v);
            n_checks++;
            if (in_sprite !== exp_in || image_addr !== exp_addr || anim_frame_out !== exp_frame) begin
                n_fail++;
                $display("FAIL random %0d (%0d,%0d): in=%b addr=%0d frame=%0d, want %b/%0d/%0d",
                         i, h, v, in_sprite, image_addr, anim_frame_out, exp_in, exp_addr, exp_frame);
            end
        end
    endtask

    initial begin
        @(negedge pixel_clk_in);
        test_reset();
        test_scale();
        test_basic_hit();
        test_anim();
        test_mid_frame();
        test_offscreen();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/coin_sprite_addr_gen.md
Name: coin_sprite_addr_gen

Overview:
Upstream stage of the coin sprite renderer. Takes the raster position (hcount/vcount) and the coin's screen position. Produces the coin sheet ROM address (image_addr) and the in_sprite flag consumed by the coin renderer. The 16x64 sprite sheet holds 4 stacked 16x16 animation frames. This block owns the animation frame sequencing and the per-frame position latching, which prevents tearing.

Parameters:
COIN_W, 16, sprite width in pixels
COIN_FRAME_H, 16, height of one animation frame in pixels
NUM_FRAMES, 4, animation frames in the sheet (power of 2)
TICKS_PER_STEP, 8, video frames per animation step (>=1)

Ports:
pixel_clk_in  input  1  pixel clock
rst_in  input  1  synchronous active-high reset
hcount_in  input  11  current pixel column
vcount_in  input  10  current pixel row
new_frame_in  input  1  single-cycle pulse at start of each video frame
coin_x_in  input  11  coin top-left column
coin_y_in  input  10  coin top-left row
coin_active_in  input  1  coin visible (not collected)
anim_en_in  input  1  animation advance enable
image_addr  output  10  coin sheet address, $clog2(COIN_W*COIN_FRAME_H*NUM_FRAMES)
in_sprite  output  1  current pixel lies inside a visible coin
anim_frame_out  output  2  current animation frame index, debug/HUD

Behaviour:
- Reset: image_addr=0, in_sprite=0, anim_frame_out=0, tick counter=0, shadow_active=0, shadow_x=0, shadow_y=0.
- Shadow latch: on a new_frame_in cycle, coin_x_in, coin_y_in and coin_active_in are registered into shadow_x, shadow_y and shadow_active. All hit tests use the shadow copies only. Mid-frame changes to the coin inputs are ignored until the next new_frame_in.
- Animation counter, updated on a new_frame_in cycle with anim_en_in=1:
  - if tick == TICKS_PER_STEP-1: tick<=0 and frame<=(frame+1) mod NUM_FRAMES (wrap 3->0);
  - else tick<=tick+1.
  - anim_en_in=0: both counters hold.
  - new_frame_in=0: no change.
- Hit test, done in 12-bit (h) / 11-bit (v) unsigned arithmetic so shadow_x+COIN_W never overflows:
  - hit_h = hcount_in >= shadow_x && hcount_in < shadow_x+COIN_W
  - hit_v = vcount_in >= shadow_y && vcount_in < shadow_y+COIN_FRAME_H
  - hit = hit_h && hit_v && shadow_active
- Address: addr = frame*COIN_W*COIN_FRAME_H + (vcount_in-shadow_y)*COIN_W + (hcount_in-shadow_x), truncated to 10 bits. The multiplies are constant powers of two, implemented as shifts.
- Latency: exactly 1 cycle. image_addr and in_sprite are registered from the current-cycle hcount/vcount and current shadow/frame state. The downstream renderer adds 3 more cycles, giving 4 cycles total from hcount_in to RGB.
- When hit=0, image_addr holds its previous value (no toggling); in_sprite=0.
- Simultaneous new_frame_in and in-window pixel: that pixel uses the pre-update shadow/frame values. Updated values take effect the following cycle.
- Coin partially off-screen (shadow_x > 1024-COIN_W): the window is clipped naturally by the raster; no wrap to column 0.
- Reset mid-frame: outputs return to reset values on the next edge. in_sprite stays 0 until a new_frame_in latches an active coin.
- anim_frame_out = frame register, 0 cycles from the register.

Optional Feature:
COIN_SCALE2X_EN
- Defined: on-screen footprint is 2*COIN_W x 2*COIN_FRAME_H. The hit window uses the doubled extents. Local offsets are right-shifted by 1 before address formation, so each texel covers 2x2 pixels. Latency is unchanged.
- Undefined: 1:1 mapping as above.

Decomposition:
- Package coin_pkg: COIN_W, COIN_FRAME_H, NUM_FRAMES, COIN_ADDR_W=10, COIN_FRAME_BITS=2, and the coin sheet size constant. The renderer also imports this package.
- One sub-module, coin_anim_counter: tick/frame counters with new_frame_in and anim_en_in gating. The top level holds the shadow latch, hit test and address pipeline register.

Test Plan:
1. Reset is released, no new_frame_in pulse, coin_active_in=1 -> in_sprite stays 0 for a full line; image_addr=0.
2. Pulse new_frame_in with coin at (100,50), active, frame 0; scan row 50 -> in_sprite=1 exactly for hcount 100..115, one cycle late. Addresses are 0..15, and row 65 gives 240..255.
3. TICKS_PER_STEP=8, anim_en_in=1; issue 32 new_frame_in pulses -> anim_frame_out steps 0,1,2,3,0 every 8 pulses. At frame 2, pixel (100,50) gives address 512.
4. Change coin_x_in to 200 mid-frame -> hits stay at 100..115 until the next new_frame_in, then move to 200..215.
5. coin at x=1020, coin_active_in=0 then 1 -> inactive: no hits. Active: hits at 1020..1023 only, no hit at hcount 0..11 on the next line.
6. Assert rst_in while in_sprite=1 with anim_frame_out=3 -> next cycle in_sprite=0, image_addr=0, anim_frame_out=0. With COIN_SCALE2X_EN, pixels (100,50)/(101,51) both give address 0 and (102,50) gives 1.
